// File: rtl/conv_output_drain.sv
// rtl/conv_output_drain.sv - output drain stage: captures result words, buffers them, streams to host
//
// Captures every final output word (with x/y/ch coordinates) flagged by
// in_valid while a layer is running, buffers it in a circular FIFO and hands
// it to the host over a valid/ready handshake. Counts accepted and drained
// results, flags dropped words, and pulses done once the whole feature map
// has been drained.
//
// Ports:
//   clk, arst_n_in            clock, asynchronous active-low reset
//   start                     one-cycle pulse arming the block for a new layer
//   in_valid, in_data,
//   in_x, in_y, in_ch         result word and its coordinates (no back-pressure)
//   out_valid, out_ready,
//   out_data, out_x, out_y,
//   out_ch                    FIFO head toward the host
//   fifo_level                occupied FIFO entries
//   overflow                  sticky: at least one word was dropped
//   done                      one-cycle pulse after the last result is popped
module conv_output_drain #(
   parameter int DATA_WIDTH         = 32,
   parameter int FIFO_DEPTH         = 8,
   parameter int FEATURE_MAP_WIDTH  = 1024,
   parameter int FEATURE_MAP_HEIGHT = 1024,
   parameter int OUTPUT_NB_CHANNELS = 64
) (
   input  logic                          clk,
   input  logic                          arst_n_in,
   input  logic                          start,
   input  logic                          in_valid,
   input  logic [DATA_WIDTH-1:0]         in_data,
   input  logic [31:0]                   in_x,
   input  logic [31:0]                   in_y,
   input  logic [31:0]                   in_ch,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic [31:0]                   out_x,
   output logic [31:0]                   out_y,
   output logic [31:0]                   out_ch,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   output logic                          done
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [31:0] TOTAL =
      32'(FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS);
   localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [31:0]           x;
      logic [31:0]           y;
      logic [31:0]           ch;
   } entry_t;

   entry_t        mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   level;
   state_t        state;
   logic [31:0]   acc_cnt;
   logic [31:0]   pop_cnt;

   logic full;
   logic push;
   logic pop;
   logic drop;

   assign out_valid  = (level != '0);
   assign full       = (level == DEPTH_L);
   assign pop        = out_valid && out_ready;
   // A full FIFO still accepts a word when the head leaves in the same cycle.
   // Words beyond the expected result count are never stored.
   assign push       = (state == S_RUN) && in_valid && (acc_cnt != TOTAL) && (!full || pop);
   assign drop       = (state == S_RUN) && in_valid && !push;

   assign out_data   = mem[rd_ptr].data;
   assign out_x      = mem[rd_ptr].x;
   assign out_y      = mem[rd_ptr].y;
   assign out_ch     = mem[rd_ptr].ch;
   assign fifo_level = level;

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         // Storage is cleared too so that out_* read zero straight out of reset.
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         state    <= S_IDLE;
         acc_cnt  <= '0;
         pop_cnt  <= '0;
         overflow <= 1'b0;
         done     <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= '{data: in_data, x: in_x, y: in_y, ch: in_ch};
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: level <= level;
         endcase

         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_RUN;
                  acc_cnt  <= '0;
                  pop_cnt  <= '0;
                  overflow <= 1'b0;
               end
            end
            S_RUN: begin
               if (push) begin
                  acc_cnt <= acc_cnt + 32'd1;
               end
               if (pop && (pop_cnt != TOTAL)) begin
                  pop_cnt <= pop_cnt + 32'd1;
               end
               if (drop) begin
                  overflow <= 1'b1;
               end
               // Leave on the edge of the final pop so DONE is the very next cycle.
               if (pop && (pop_cnt == TOTAL - 32'd1)) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_output_drain.sv
// tb/tb_conv_output_drain.sv - directed self-checking bench for conv_output_drain
module tb_conv_output_drain;

   logic        clk = 1'b0;
   logic        arst_n_in;
   logic        start;
   logic        in_valid;
   logic [31:0] in_data;
   logic [31:0] in_x;
   logic [31:0] in_y;
   logic [31:0] in_ch;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [31:0] out_x;
   logic [31:0] out_y;
   logic [31:0] out_ch;
   logic [2:0]  fifo_level;
   logic        overflow;
   logic        done;

   int checks = 0;
   int errors = 0;

   conv_output_drain #(
      .DATA_WIDTH         (32),
      .FIFO_DEPTH         (4),
      .FEATURE_MAP_WIDTH  (2),
      .FEATURE_MAP_HEIGHT (2),
      .OUTPUT_NB_CHANNELS (2)
   ) dut (
      .clk        (clk),
      .arst_n_in  (arst_n_in),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_x       (in_x),
      .in_y       (in_y),
      .in_ch      (in_ch),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_x      (out_x),
      .out_y      (out_y),
      .out_ch     (out_ch),
      .fifo_level (fifo_level),
      .overflow   (overflow),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full layer: 8 words every other cycle, host always ready.
   task automatic stream8(input logic [31:0] base);
      start = 1'b1;
      tick();
      start     = 1'b0;
      out_ready = 1'b1;
      check("start_ovf", 32'(overflow), 0);
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = base + 32'(i);
         in_x     = i % 2;
         in_y     = (i / 2) % 2;
         in_ch    = i / 4;
         tick();
         in_valid = 1'b0;
         check("s8_valid", 32'(out_valid), 1);
         check("s8_data", out_data, base + 32'(i));
         check("s8_x", out_x, i % 2);
         check("s8_y", out_y, (i / 2) % 2);
         check("s8_ch", out_ch, i / 4);
         check("s8_level", 32'(fifo_level), 1);
         tick();
         check("s8_drained", 32'(fifo_level), 0);
         check("s8_done", 32'(done), (i == 7) ? 1 : 0);
      end
      tick();
      check("s8_done_end", 32'(done), 0);
      check("s8_ovf", 32'(overflow), 0);
   endtask

   initial begin
      int  lvl_m;
      int  sent;
      int  popped;
      logic ovf_m;
      logic pop_m;
      logic push_m;
      logic done_m;

      arst_n_in = 1'b0;
      start     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_x      = '0;
      in_y      = '0;
      in_ch     = '0;
      out_ready = 1'b0;
      tick();
      tick();
      check("rst_valid", 32'(out_valid), 0);
      check("rst_data", out_data, 0);
      check("rst_level", 32'(fifo_level), 0);
      check("rst_ovf", 32'(overflow), 0);
      check("rst_done", 32'(done), 0);
      arst_n_in = 1'b1;
      tick();

      // in_valid while idle is ignored
      in_valid = 1'b1;
      in_data  = 32'haa;
      tick();
      in_valid = 1'b0;
      check("idle_level", 32'(fifo_level), 0);
      check("idle_valid", 32'(out_valid), 0);
      check("idle_ovf", 32'(overflow), 0);

      // basic stream
      stream8(32'h10);

      // back-pressure, full simultaneous push/pop, drop on full
      start = 1'b1;
      tick();
      start     = 1'b0;
      out_ready = 1'b0;
      in_x      = '0;
      in_y      = '0;
      in_ch     = '0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h20 + 32'(i);
         tick();
         in_valid = 1'b0;
         check("bp_level", 32'(fifo_level), i + 1);
         check("bp_head", out_data, 32'h20);
         tick();
      end
      in_valid  = 1'b1;
      in_data   = 32'h24;
      out_ready = 1'b1;
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("sim_level", 32'(fifo_level), 4);
      check("sim_ovf", 32'(overflow), 0);
      check("sim_head", out_data, 32'h21);
      in_valid = 1'b1;
      in_data  = 32'h25;
      tick();
      in_valid = 1'b0;
      check("drop_level", 32'(fifo_level), 4);
      check("drop_ovf", 32'(overflow), 1);
      check("drop_head", out_data, 32'h21);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("run_start_ignored", 32'(overflow), 1);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("rel_data", out_data, 32'h21 + 32'(i));
         tick();
      end
      check("rel_level", 32'(fifo_level), 0);
      check("rel_valid", 32'(out_valid), 0);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h26 + 32'(i);
         tick();
         in_valid = 1'b0;
         check("tail_data", out_data, 32'h26 + 32'(i));
         tick();
         check("tail_done", 32'(done), (i == 2) ? 1 : 0);
      end
      check("sticky_ovf", 32'(overflow), 1);
      tick();
      out_ready = 1'b0;

      // wrap-around with stalls, excess word after 8 accepted
      start = 1'b1;
      tick();
      start = 1'b0;
      check("wrap_start_ovf", 32'(overflow), 0);
      lvl_m  = 0;
      sent   = 0;
      popped = 0;
      ovf_m  = 1'b0;
      for (int c = 0; c < 32; c++) begin
         in_valid  = (c % 2 == 0) && (c <= 16);
         in_data   = 32'h30 + 32'(sent);
         out_ready = (c % 8) >= 5;
         pop_m     = out_ready && (lvl_m > 0);
         push_m    = in_valid && (sent < 8) && ((lvl_m < 4) || pop_m);
         done_m    = pop_m && (popped == 7);
         if (in_valid && !push_m) ovf_m = 1'b1;
         if (push_m) begin
            lvl_m++;
            sent++;
         end
         if (pop_m) begin
            lvl_m--;
            popped++;
         end
         tick();
         check("wrap_level", 32'(fifo_level), lvl_m);
         check("wrap_ovf", 32'(overflow), 32'(ovf_m));
         check("wrap_done", 32'(done), 32'(done_m));
         if (lvl_m > 0) check("wrap_data", out_data, 32'h30 + 32'(popped));
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;

      // reset mid-run with 3 words buffered
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h40 + 32'(i);
         in_x     = 32'h7;
         tick();
         in_valid = 1'b0;
         tick();
      end
      check("pre_rst_level", 32'(fifo_level), 3);
      arst_n_in = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 0);
      check("mid_rst_data", out_data, 0);
      check("mid_rst_x", out_x, 0);
      check("mid_rst_level", 32'(fifo_level), 0);
      check("mid_rst_ovf", 32'(overflow), 0);
      check("mid_rst_done", 32'(done), 0);
      tick();
      arst_n_in = 1'b1;
      tick();
      stream8(32'h50);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_output_drain.md
# conv_output_drain

Output-side stage of the convolution accelerator. Sits directly downstream of the controller/datapath pair: captures every final output word flagged by `in_valid` together with its (x, y, ch) coordinates, buffers it in a small FIFO, and streams it to the host over a valid/ready handshake. It also counts drained results, flags lost words, and pulses `done` once the full feature map has left the block.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of one output word.
- `FIFO_DEPTH`, 8: number of FIFO entries; must be a power of 2 and at least 2.
- `FEATURE_MAP_WIDTH`, 1024: x extent.
- `FEATURE_MAP_HEIGHT`, 1024: y extent.
- `OUTPUT_NB_CHANNELS`, 64: channel extent.
- TOTAL (derived): `FEATURE_MAP_WIDTH*FEATURE_MAP_HEIGHT*OUTPUT_NB_CHANNELS`, the expected result count.

Ports:
- `clk`  in  1  clock.
- `arst_n_in`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse that arms the block for a new layer.
- `in_valid`  in  1  final output word present this cycle. There is no back-pressure toward the source.
- `in_data`  in  DATA_WIDTH  output word.
- `in_x`, `in_y`, `in_ch`  in  32 each  coordinates of `in_data`.
- `out_valid`  out  1  FIFO head is valid.
- `out_ready`  in  1  host accepts the head.
- `out_data`  out  DATA_WIDTH  head word.
- `out_x`, `out_y`, `out_ch`  out  32 each  head coordinates.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- `overflow`  out  1  sticky flag: at least one word was dropped.
- `done`  out  1  one-cycle pulse after the last result is popped.

## Operation
- FSM states and transitions:
  - IDLE: `start` moves to RUN.
  - RUN: moves to DONE in the cycle after the popped count reaches TOTAL.
  - DONE: lasts exactly 1 cycle, then returns to IDLE.
- Push condition: state is RUN, `in_valid` is 1, and either the FIFO is not full or a pop happens in the same cycle.
- Pop condition: `out_valid` and `out_ready` are both 1.
- Push and pop in the same cycle leave the level unchanged. When the FIFO is full, this is the only way a write can succeed.
- Dropped words. A word is dropped, and `overflow` is set, in either case:
  - `in_valid` arrives in RUN while the FIFO is full and no pop happens that cycle.
  - `in_valid` arrives after the accepted count has already reached TOTAL.
- `in_valid` in IDLE or DONE is ignored and does not set `overflow`.
- `overflow` clears only on `start` or reset.
- Counters:
  - The accepted counter and popped counter are 32 bits each.
  - Both are cleared on `start` in IDLE.
  - Each saturates at TOTAL.
- `start` while in RUN or DONE is ignored.
- Storage is a circular buffer with read and write pointers of $clog2(FIFO_DEPTH) bits. Pointers wrap from FIFO_DEPTH-1 to 0.
- `out_*` are driven from the entry at the read pointer.
- `out_valid` equals (level ≠ 0).
- While `out_valid` is 1 and `out_ready` is 0, `out_*` hold stable.

## Timing
- Reset values: FSM in IDLE, pointers 0, level 0, counters 0. Outputs reset to `out_valid`=0, `out_data`/`out_x`/`out_y`/`out_ch`=0, `fifo_level`=0, `overflow`=0, `done`=0.
- Reset asserted mid-operation discards all buffered words immediately.
- Latency: a word pushed on edge N appears on `out_*` with `out_valid`=1 after edge N, if the FIFO was empty. There is no combinational path from `in_*` to `out_*`.
- `fifo_level` updates on the edge of the push/pop.
- `done` is high for exactly the DONE cycle, which is the cycle after the edge that performed the TOTAL-th pop.
- `out_ready` may be high while `out_valid`=0; this has no effect.
- The block absorbs up to FIFO_DEPTH words of host stall. The source issues at most one word every 2 cycles (MAC pair), so a host that is ready at least half the time never overflows.

## Test plan
Bench parameters: W=2, H=2, C=2 (TOTAL=8), FIFO_DEPTH=4.
- Basic stream: reset, `start`, then 8 words 0x10..0x17 every other cycle, `out_ready`=1 throughout. Expect:
  - each word on `out_*` one cycle after its push, in order, with matching coordinates;
  - `done` high for 1 cycle after the 8th pop;
  - `overflow`=0.
- Back-pressure: `out_ready`=0 and push 4 words. Expect `fifo_level`=4 and `out_data`=first word held stable. Then push a 5th word with `out_ready`=0. Expect it dropped and `overflow`=1. Then release `out_ready`. Expect the 4 buffered words out in order.
- Full simultaneous: FIFO full with `out_ready`=1 and `in_valid`=1 in the same cycle. Expect the level stays 4, no drop, `overflow` stays 0.
- Wrap-around: 8 words with alternating stalls so the pointers wrap twice. Expect output order identical to input order.
- Excess and idle input: after 8 accepted words, a 9th `in_valid`. Expect it dropped and `overflow`=1. `in_valid` in IDLE before `start`. Expect no push and `overflow`=0.
- Reset mid-run: assert `arst_n_in` with 3 words buffered. Expect all outputs at reset values within the same cycle. After `start`, expect a fresh count with `done` only after 8 new pops.
